coherent_averager: RTL and testbench

COHERENT_AVERAGER -- requirements
Module: coherent_averager

---
 rtl/coherent_averager.sv | 140 ++++++++++++++
 tb/tb_coherent_averager.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_averager.sv
// Coherent averager: sums K = 2^K_LOG2 frames of M samples into an
// accumulator RAM, then streams the per-index averages out once.
module coherent_averager #(
   parameter int M      = 32,
   parameter int Q      = 12,
   parameter int K_LOG2 = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         data_valid,
   input  logic [Q-1:0] data,
   output logic         out_valid,
   output logic [Q-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic         done
);

   localparam int AW = Q + K_LOG2;
   localparam int NW = (M > 1) ? $clog2(M) : 1;
   localparam int KW = K_LOG2 + 1;
   localparam logic [NW-1:0] N_LAST = NW'(M - 1);
   localparam logic [KW-1:0] K_LAST = KW'((1 << K_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT, DONE} state_t;

   state_t        state, state_nxt;
   logic [NW-1:0] n, n_nxt;
   logic [NW-1:0] i, i_nxt;
   logic [KW-1:0] k, k_nxt;
   logic          wr;
   logic [AW-1:0] wr_data;
   logic [AW-1:0] rd_acc;
   logic [AW-1:0] rd_out;
   logic          ov_nxt;
   logic          ol_nxt;
   logic [Q-1:0]  od_nxt;
   logic          busy_nxt;
   logic          done_nxt;

   logic [AW-1:0] acc [M];

   assign rd_acc = acc[n];
   assign rd_out = acc[i];

   // Frame 0 overwrites, so a fresh run never sees stale sums.
   assign wr_data = (k == '0) ? AW'(data) : rd_acc + AW'(data);

   always_ff @(posedge clk) begin
      if (wr) begin
         acc[n] <= wr_data;
      end
   end

   always_comb begin
      state_nxt = state;
      n_nxt     = n;
      k_nxt     = k;
      i_nxt     = i;
      wr        = 1'b0;
      ov_nxt    = 1'b0;
      ol_nxt    = 1'b0;
      od_nxt    = '0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = ACCUM;
               n_nxt     = '0;
               k_nxt     = '0;
            end
         end
         ACCUM: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (data_valid) begin
               wr = 1'b1;
               if (n == N_LAST) begin
                  n_nxt = '0;
                  if (k == K_LAST) begin
                     state_nxt = OUTPUT;
                     i_nxt     = '0;
                  end else begin
                     k_nxt = k + 1'b1;
                  end
               end else begin
                  n_nxt = n + 1'b1;
               end
            end
         end
         OUTPUT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else begin
               ov_nxt = 1'b1;
               od_nxt = rd_out[AW-1:K_LOG2];
               ol_nxt = (i == N_LAST);
               if (i == N_LAST) begin
                  state_nxt = DONE;
               end else begin
                  i_nxt = i + 1'b1;
               end
            end
         end
         DONE: begin
            if (!enable) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == ACCUM) || (state_nxt == OUTPUT);
      done_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         n         <= '0;
         k         <= '0;
         i         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         n         <= n_nxt;
         k         <= k_nxt;
         i         <= i_nxt;
         out_valid <= ov_nxt;
         out_data  <= od_nxt;
         out_last  <= ol_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_coherent_averager.sv
// Directed bench for coherent_averager with an expected-output queue
// filled from a bench-side frame-sum model.
module tb_coherent_averager;

   localparam int M  = 32;
   localparam int Q  = 12;
   localparam int KL = 4;
   localparam int K  = 1 << KL;
   localparam int NS = M * K;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         enable = 1'b0;
   logic         data_valid = 1'b0;
   logic [Q-1:0] data = '0;
   logic         out_valid;
   logic [Q-1:0] out_data;
   logic         out_last;
   logic         busy;
   logic         done;

   typedef struct packed {
      logic [Q-1:0] d;
      logic         l;
   } exp_t;

   exp_t         exp_q [$];
   int           total = 0;
   int           bad = 0;
   logic [Q-1:0] samp [NS];
   logic [Q-1:0] tbl [M];

   coherent_averager #(.M(M), .Q(Q), .K_LOG2(KL)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .data_valid(data_valid),
      .data(data),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_last(out_last),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (reset_n && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_last", 32'(out_last), 32'(e.l));
         end
      end
   end

   // Data presented while idle must be ignored.
   task automatic start();
      @(negedge clk);
      enable = 1'b1;
      data_valid = 1'b1;
      data = Q'($urandom);
   endtask

   task automatic drive(input int cnt, input bit gaps);
      for (int s = 0; s < cnt; s++) begin
         if (gaps && s > 0) begin
            @(negedge clk);
            data_valid = 1'b0;
            data = Q'($urandom);
         end
         @(negedge clk);
         data_valid = 1'b1;
         data = samp[s];
      end
   endtask

   task automatic push_exp();
      int sum [M];
      for (int n = 0; n < M; n++) sum[n] = 0;
      for (int s = 0; s < NS; s++) sum[s % M] += int'(samp[s]);
      for (int n = 0; n < M; n++) begin
         exp_q.push_back('{d: Q'(sum[n] >> KL), l: (n == M - 1)});
      end
   endtask

   task automatic collect(input bit dv);
      int lat = 0;
      int cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         data_valid = dv;
         data = Q'($urandom);
      end while (!out_valid && lat < 8);
      chk("first_valid_in_time", 32'(out_valid && lat <= 3), 32'd1);
      if (out_valid) cnt = 1;
      while (out_valid && cnt < M + 4) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("valid_count", 32'(cnt), 32'(M));
      chk("done_after_run", 32'(done), 32'd1);
      chk("busy_after_run", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic stop();
      @(negedge clk);
      enable = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      chk("done_cleared", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      for (int n = 0; n < M; n++) begin
         real v;
         v = 2048.0 + 2000.0 * $sin(2.0 * 3.14159265358979 * real'(n) / real'(M));
         tbl[n] = Q'($rtoi(v + 0.5));
      end

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // sine, continuous, input kept toggling during readout and DONE
      for (int s = 0; s < NS; s++) samp[s] = tbl[s % M];
      start();
      drive(NS, 1'b0);
      push_exp();
      collect(1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         data_valid = 1'b1;
         chk("done_no_reemit", 32'(out_valid), 32'd0);
         chk("done_held", 32'(done), 32'd1);
      end
      stop();

      // full-scale constant
      for (int s = 0; s < NS; s++) samp[s] = 12'hFFF;
      start();
      drive(NS, 1'b0);
      push_exp();
      collect(1'b0);
      stop();

      // ramp plus +/-8 LSB noise
      for (int s = 0; s < NS; s++) begin
         samp[s] = Q'(200 + (s % M) * 100 + int'($urandom_range(0, 16)) - 8);
      end
      start();
      drive(NS, 1'b0);
      push_exp();
      collect(1'b0);
      stop();

      // sine with 1-0-1-0 valid gaps
      for (int s = 0; s < NS; s++) samp[s] = tbl[s % M];
      start();
      drive(NS, 1'b1);
      push_exp();
      collect(1'b0);
      stop();

      // abort at frame 7, then a fresh run with different data
      for (int s = 0; s < NS; s++) samp[s] = Q'($urandom);
      start();
      drive(7 * M + 5, 1'b0);
      @(negedge clk);
      enable = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      for (int s = 0; s < NS; s++) samp[s] = Q'((s % M) * 128 + s / M);
      start();
      drive(NS, 1'b0);
      push_exp();
      collect(1'b0);
      stop();

      // reset in the middle of readout
      for (int s = 0; s < NS; s++) samp[s] = Q'(4095 - (s % M) * 60);
      start();
      drive(NS, 1'b0);
      push_exp();
      repeat (5) @(negedge clk);
      chk("mid_output_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_out_data", 32'(out_data), 32'd0);
      chk("rst_mid_out_last", 32'(out_last), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      exp_q.delete();
      enable = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      for (int s = 0; s < NS; s++) samp[s] = Q'(1000 + (s % M) * 3);
      start();
      drive(NS, 1'b0);
      chk("done_low_in_accum", 32'(done), 32'd0);
      push_exp();
      collect(1'b0);
      stop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
